uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit, SHALL be at least 2.
REQ-002 Parameter DATA_W, default 8: data bits per frame, range 5..9.
REQ-003 Parameter PARITY, default 0: 0 means none, 1 means even, 2 means odd.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16: word buffer depth, power of 2, at least 2.
REQ-006 Port clk, in, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst, in, 1: reset, synchronous and active-high.
REQ-008 Port s_data, in, DATA_W: word to transmit.
REQ-009 Port s_valid, in, 1: s_data is valid.
REQ-010 Port s_ready, out, 1: the block can accept a word this cycle.
REQ-011 Port tx_o, out, 1: serial line, idle high.
REQ-012 Port busy, out, 1: a frame is in progress or the FIFO is non-empty.
REQ-013 Port fifo_level, out, $clog2(FIFO_DEPTH)+1: number of words currently buffered.

Function
REQ-014 A word SHALL be accepted on every rising edge where s_valid and s_ready are both high.
REQ-015 s_ready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL be driven combinationally from registered state only.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop one word, load the shift register, and enter START.
REQ-018 START SHALL drive tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL drive the DATA_W bits LSB first, each for CLKS_PER_BIT cycles.
REQ-020 After DATA, the FSM SHALL go to PAR if PARITY!=0, otherwise to STOP.
REQ-021 PAR SHALL drive the XOR of the data bits for even parity, or its inverse for odd parity, for one bit period.
REQ-022 STOP SHALL drive tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 On leaving STOP, the FSM SHALL pop the next word and enter START directly if the FIFO is non-empty (zero idle gap), otherwise enter IDLE.
REQ-024 tx_o SHALL be a register.
REQ-025 With an empty FIFO and the FSM in IDLE, tx_o SHALL fall on the 2nd rising edge after the accepting edge.
REQ-026 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-027 A push is impossible when the FIFO is full; s_valid SHALL be held off and the data not lost.
REQ-028 A frame SHALL last exactly (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-029 Changes to s_data or s_valid mid-frame SHALL NOT affect the frame in flight.
REQ-030 busy SHALL equal (state!=IDLE) or (fifo_level!=0).

Reset
REQ-031 On rst, the block SHALL set tx_o=1, state=IDLE, fifo_level=0, busy=0, s_ready=1, with the bit counter and baud counter cleared.
REQ-032 A reset asserted mid-frame SHALL abort the frame, drive tx_o=1 from the next edge, and flush all buffered words.
REQ-033 A push on a reset edge SHALL be discarded.

Structure
REQ-034 Package uart_pkg SHALL hold the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state type.
REQ-035 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, level).
REQ-036 All other logic SHALL reside in uart_frame_tx.

Verification
REQ-037 Default parameters, push 0xA5: tx_o SHALL be 0,1,0,1,0,0,1,0,1,1, each bit lasting 10 cycles, for 100 cycles total, with a 2-cycle latency from acceptance.
REQ-038 PARITY=1, push 0x07: parity bit = 1. PARITY=2, push 0x07: parity bit = 0. Frame length SHALL be 110 cycles.
REQ-039 Push 512 words forming the ramp 00,00,01,01,...,FF,FF: the frames SHALL be contiguous (no idle gap), the decoded bytes SHALL match the ramp, and busy SHALL fall 1 cycle after the last stop bit.
REQ-040 Hold s_valid high for 20 words while tx_o is stalled at the start of a frame: fifo_level SHALL reach 16, s_ready SHALL drop, and no word SHALL be lost or duplicated.
REQ-041 Pulse rst during data bit 3 of a frame with 5 words queued: tx_o=1 and fifo_level=0 SHALL hold on the next edge, and no further frames SHALL follow.
REQ-042 STOP_BITS=2, DATA_W=7, CLKS_PER_BIT=4, push 0x55: frame SHALL be 40 cycles with the stop high for 8 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: parity encodings,
// the transmit FSM state type and the parity helper.
package uart_pkg;

  // Parity selection values for the PARITY parameter
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Transmit FSM states, one per segment of a serial frame
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Parity bit for a word zero-extended to 9 bits.
  // Even parity makes the total count of ones even, odd parity makes it odd.
  function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: calc_parity = p;
      PAR_ODD:  calc_parity = ~p;
      default:  calc_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. rdata always shows the oldest
// entry; push is ignored when full and pop is ignored when empty, so the
// caller can never corrupt the occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 32'd1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LVL_FULL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; reset flushes every buffered word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; a push on a reset edge is dropped with the flush
  always_ff @(posedge clk) begin
    if (w_do_push && !rst) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter. Words are queued in a FIFO and sent as
// start / DATA_W data bits (LSB first) / optional parity / stop bits.
// Back-to-back frames are sent with no idle gap while words remain queued.
// The line register samples the FSM's bit value, so tx_o trails the FSM
// state by one clock; every segment keeps its exact length.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32'd10,
  parameter int unsigned DATA_W       = 32'd8,
  parameter int unsigned PARITY       = 32'd0,
  parameter int unsigned STOP_BITS    = 32'd1,
  parameter int unsigned FIFO_DEPTH   = 32'd16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 32'd1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 32'd1);
  localparam logic              PAR_EN    = (PARITY != 32'd0);
  localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

  // FIFO interface
  logic                          w_fifo_push;
  logic                          w_fifo_pop;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [DATA_W-1:0]             w_fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]   w_fifo_level;

  // FSM state and datapath registers
  tx_state_t                     r_state;
  logic [BAUD_W-1:0]             r_baud_cnt;
  logic [3:0]                    r_bit_cnt;
  logic [DATA_W-1:0]             r_shift;
  logic                          r_par;
  logic                          r_tx;

  // Decoded helpers
  logic                          w_baud_done;
  logic                          w_data_last;
  logic                          w_stop_last;
  logic                          w_tx_next;
  logic [8:0]                    w_word9;
  logic                          w_load_par;

  // The handshake depends only on the registered FIFO occupancy
  assign s_ready     = ~w_fifo_full;
  assign w_fifo_push = s_valid & s_ready;
  assign fifo_level  = w_fifo_level;
  assign busy        = (r_state != ST_IDLE) | (w_fifo_level != '0);
  assign tx_o        = r_tx;

  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_data_last = (r_bit_cnt == DATA_LAST);
  assign w_stop_last = (r_bit_cnt == STOP_LAST);

  // Parity is computed once from the whole word as it leaves the FIFO
  assign w_word9    = 9'(w_fifo_rdata);
  assign w_load_par = calc_parity(w_word9, PAR_MODE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .wdata (s_data),
    .pop   (w_fifo_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (w_fifo_level)
  );

  // Pop a word when idle, or at the end of the last stop bit to chain frames
  always_comb begin
    w_fifo_pop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fifo_pop = ~w_fifo_empty;
      end
      ST_STOP: begin
        if (w_baud_done && w_stop_last) begin
          w_fifo_pop = ~w_fifo_empty;
        end else begin
          w_fifo_pop = 1'b0;
        end
      end
      default: begin
        w_fifo_pop = 1'b0;
      end
    endcase
  end

  // Line level the current FSM state calls for; registered into tx_o
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      ST_IDLE:  w_tx_next = 1'b1;
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = r_shift[0];
      ST_PAR:   w_tx_next = r_par;
      ST_STOP:  w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Frame sequencer: baud timing, bit counting, shifting and the line register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= 4'd0;
          if (w_fifo_pop) begin
            r_shift <= w_fifo_rdata;
            r_par   <= w_load_par;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_shift    <= r_shift >> 1;
            if (w_data_last) begin
              r_bit_cnt <= 4'd0;
              r_state   <= PAR_EN ? ST_PAR : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        ST_PAR: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_state    <= ST_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (w_stop_last) begin
              r_bit_cnt <= 4'd0;
              if (w_fifo_pop) begin
                // Next word starts immediately: no idle time on the line
                r_shift <= w_fifo_rdata;
                r_par   <= w_load_par;
                r_state <= ST_START;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_baud_cnt <= '0;
          r_bit_cnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx. Four instances cover the default,
// even-parity, odd-parity and 7-bit/2-stop/4-clock configurations; a shared
// monitor decodes the selected line cycle by cycle against queued frames.
module tb_uart_frame_tx;

  typedef struct packed {
    logic [15:0] bits;
    logic        contig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  logic [8:0]  drv_data;
  logic        drv_valid;
  int          sel;

  logic [3:0]  v_a;
  logic [3:0]  tx_a;
  logic [3:0]  rdy_a;
  logic [3:0]  bsy_a;
  logic [4:0]  lvl_a [4];

  logic        tx_m;
  logic        rdy_m;
  logic        bsy_m;
  logic [4:0]  lvl_m;

  int m_cpb, m_dw, m_par, m_stop;
  bit mon_en = 1'b0;

  exp_t        exp_q[$];
  logic [15:0] frame_log[$];
  int          start_log[$];
  int          last_start = 0;
  int          prev_end = -100;
  int          extra_frames = 0;
  int          last_acc = 0;
  int          max_lvl = 0;
  bit          ready_low = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v_a[0] = drv_valid && (sel == 0);
  assign v_a[1] = drv_valid && (sel == 1);
  assign v_a[2] = drv_valid && (sel == 2);
  assign v_a[3] = drv_valid && (sel == 3);

  uart_frame_tx u_def (
    .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(v_a[0]),
    .s_ready(rdy_a[0]), .tx_o(tx_a[0]), .busy(bsy_a[0]), .fifo_level(lvl_a[0]));

  uart_frame_tx #(.PARITY(1)) u_even (
    .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(v_a[1]),
    .s_ready(rdy_a[1]), .tx_o(tx_a[1]), .busy(bsy_a[1]), .fifo_level(lvl_a[1]));

  uart_frame_tx #(.PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(v_a[2]),
    .s_ready(rdy_a[2]), .tx_o(tx_a[2]), .busy(bsy_a[2]), .fifo_level(lvl_a[2]));

  uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(7), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .s_data(drv_data[6:0]), .s_valid(v_a[3]),
    .s_ready(rdy_a[3]), .tx_o(tx_a[3]), .busy(bsy_a[3]), .fifo_level(lvl_a[3]));

  always_comb begin
    tx_m  = tx_a[sel];
    rdy_m = rdy_a[sel];
    bsy_m = bsy_a[sel];
    lvl_m = lvl_a[sel];
  end

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference frame: bit 0 is the start bit, then data LSB first, parity, stops
  function automatic logic [15:0] make_frame(input logic [8:0] d);
    logic [15:0] f;
    int          k;
    logic        p;
    f = 16'h0000;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < m_dw; i++) begin
      f[k] = d[i];
      p    = p ^ d[i];
      k++;
    end
    if (m_par == 1) begin
      f[k] = p;
      k++;
    end else if (m_par == 2) begin
      f[k] = ~p;
      k++;
    end
    for (int i = 0; i < m_stop; i++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  // Line monitor: captures every cycle of a frame and scores it
  initial begin : monitor
    int          nb;
    int          st;
    int          glitch;
    logic [15:0] obs;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en && tx_m == 1'b0) begin
        st         = int'(cyc);
        last_start = st;
        nb         = 1 + m_dw + ((m_par != 0) ? 1 : 0) + m_stop;
        obs        = 16'h0000;
        glitch     = 0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < m_cpb; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) obs[b] = tx_m;
            else if (tx_m !== obs[b]) glitch++;
          end
        end
        frame_log.push_back(obs);
        start_log.push_back(st);
        check_value("frame_glitch", glitch, 0);
        if (exp_q.size() == 0) begin
          extra_frames++;
        end else begin
          e = exp_q.pop_front();
          check_value("frame_bits", obs, e.bits);
          if (e.contig) check_value("frame_gap", st - prev_end - 1, 0);
        end
        prev_end = int'(cyc);
      end
    end
  end

  task automatic configure(input int s, input int cpb, input int dw, input int par, input int stop);
    sel    = s;
    m_cpb  = cpb;
    m_dw   = dw;
    m_par  = par;
    m_stop = stop;
    frame_log.delete();
    start_log.delete();
    extra_frames = 0;
    repeat (2) @(negedge clk);
  endtask

  // Present a word and hold it until accepted; queue its expected frame
  task automatic push_word(input logic [8:0] d, input logic contig);
    int   g;
    exp_t e;
    g         = 0;
    drv_data  = d;
    drv_valid = 1'b1;
    while (!rdy_m && g < 5000) begin
      ready_low = 1'b1;
      @(negedge clk);
      g++;
    end
    if (int'(lvl_m) > max_lvl) max_lvl = int'(lvl_m);
    if (!rdy_m) begin
      check_value("push_timeout_ready", rdy_m, 1);
    end else begin
      e.bits   = make_frame(d);
      e.contig = contig;
      exp_q.push_back(e);
      last_acc = int'(cyc) + 1;
    end
    @(negedge clk);
    if (int'(lvl_m) > max_lvl) max_lvl = int'(lvl_m);
  endtask

  task automatic release_bus();
    drv_valid = 1'b0;
    drv_data  = 9'($urandom);
  endtask

  // Wait for busy to clear; it must clear one cycle after the FSM's last stop cycle
  task automatic wait_done(input string tag, input int exp_len);
    int g;
    g = 0;
    while (bsy_m && g < 60000) begin
      drv_data = 9'($urandom);
      @(negedge clk);
      g++;
    end
    if (bsy_m) begin
      check_value({tag, "_busy_timeout"}, bsy_m, 0);
    end else begin
      check_value({tag, "_frame_len"}, int'(cyc) - last_start + 1, exp_len);
    end
    repeat (3) @(negedge clk);
    check_value({tag, "_queue_left"}, exp_q.size(), 0);
    check_value({tag, "_extra_frames"}, extra_frames, 0);
  endtask

  task automatic run_pair(input string tag, input logic [8:0] w0, input logic [8:0] w1,
                          input logic [15:0] exp_frame, input int exp_len);
    int acc0;
    push_word(w0, 1'b0);
    acc0 = last_acc;
    push_word(w1, 1'b1);
    release_bus();
    wait_done(tag, exp_len);
    check_value({tag, "_frame0"}, (frame_log.size() > 0) ? frame_log[0] : 16'h0000, exp_frame);
    check_value({tag, "_latency"}, (start_log.size() > 0) ? start_log[0] - acc0 : -1, 2);
  endtask

  initial begin : main
    int g;
    int st;
    int lows;
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_data  = 9'h000;
    sel       = 0;
    m_cpb = 10; m_dw = 8; m_par = 0; m_stop = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_value("rst_tx", tx_a, 4'hF);
    check_value("rst_ready", rdy_a, 4'hF);
    check_value("rst_busy", bsy_a, 4'h0);
    check_value("rst_level", lvl_a[0], 0);

    mon_en = 1'b1;

    configure(0, 10, 8, 0, 1);
    run_pair("a5", 9'h0A5, 9'h03C, 16'h034A, 100);

    configure(1, 10, 8, 1, 1);
    run_pair("even07", 9'h007, 9'h0C3, 16'h060E, 110);

    configure(2, 10, 8, 2, 1);
    run_pair("odd07", 9'h007, 9'h081, 16'h040E, 110);

    configure(3, 4, 7, 0, 2);
    run_pair("s2_55", 9'h055, 9'h02A, 16'h03AA, 40);

    // Hold s_valid for 20 words while the first frame occupies the line
    configure(0, 10, 8, 0, 1);
    max_lvl   = 0;
    ready_low = 1'b0;
    for (int i = 0; i < 20; i++) push_word(9'($urandom_range(0, 255)), (i != 0) ? 1'b1 : 1'b0);
    release_bus();
    check_value("stall_max_level", max_lvl, 16);
    check_value("stall_ready_dropped", ready_low, 1);
    wait_done("stall", 100);
    check_value("stall_frames", frame_log.size(), 20);

    // 512-word ramp 00,00,01,01,...: contiguous frames checked by the monitor
    configure(0, 10, 8, 0, 1);
    for (int i = 0; i < 512; i++) push_word(9'(i >> 1), (i != 0) ? 1'b1 : 1'b0);
    release_bus();
    wait_done("ramp", 100);
    check_value("ramp_frames", frame_log.size(), 512);

    // Reset during data bit 3 with five words queued
    configure(0, 10, 8, 0, 1);
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) push_word(9'(8'h11 * (i + 1)), 1'b0);
    release_bus();
    exp_q.delete();
    g = 0;
    while (tx_m && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_value("rst_test_start_seen", tx_m, 0);
    st = int'(cyc);
    while (int'(cyc) < st + 45 && g < 200) begin
      @(negedge clk);
      g++;
    end
    rst       = 1'b1;
    drv_valid = 1'b1;
    drv_data  = 9'h0F0;
    @(negedge clk);
    rst       = 1'b0;
    drv_valid = 1'b0;
    check_value("midrst_tx", tx_m, 1);
    check_value("midrst_level", lvl_m, 0);
    check_value("midrst_busy", bsy_m, 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_m == 1'b0 || bsy_m == 1'b1) lows++;
    end
    check_value("midrst_quiet_cycles", lows, 0);
    check_value("midrst_level_after", lvl_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
